// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: receive-word handshake between the UART front end and its consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 parity_err;
  logic                 frame_err;
  logic                 valid;
  logic                 ready;
  logic                 overrun;
  modport master (output data_out, parity_err, frame_err, valid, overrun, input ready);
  modport slave  (input data_out, parity_err, frame_err, valid, overrun, output ready);
endinterface

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with error flags and a FWFT output FIFO.
// Define UART_RX_MAJORITY_EN to take each bit as a 2-of-3 vote around the bit centre.
module uart_rx_param #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  uart_rx_param_if.master  bus
);
  localparam int TICK_CNT = CLK_FREQ / BAUD_RATE;
  localparam int HALF     = TICK_CNT / 2;
  localparam int CW       = $clog2(TICK_CNT);
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int FW       = DATA_BITS + 2;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t               state, state_n;
  logic                 rx_m, rx_s, rx_d;
  logic [CW-1:0]        cnt;
  logic [3:0]           bidx;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr;
  logic                 samp, bit_v, fall, last_data, last_stop;
  logic                 push, pop, full, wr;
  logic [FW-1:0]        mem [FIFO_DEPTH];
  logic [AW:0]          wp, rp;
  // Synchroniser resets to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge reset)
    if (reset) {rx_m, rx_s, rx_d} <= 3'b111;
    else       {rx_m, rx_s, rx_d} <= {rx, rx_m, rx_s};
  assign fall      = rx_d & ~rx_s;
  assign last_data = bidx == 4'(DATA_BITS - 1);
  assign last_stop = bidx == 4'(STOP_BITS - 1);
`ifdef UART_RX_MAJORITY_EN
  logic s0, s1;
  always_ff @(posedge clk or posedge reset)
    if (reset) {s0, s1} <= 2'b11;
    else begin
      if (cnt == CW'(HALF - 1)) s0 <= rx_s;
      if (cnt == CW'(HALF))     s1 <= rx_s;
    end
  assign samp  = state != IDLE && cnt == CW'(HALF + 1);
  assign bit_v = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
`else
  assign samp  = state != IDLE && cnt == CW'(HALF);
  assign bit_v = rx_s;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fall ? START : IDLE;
      START:   state_n = samp ? (bit_v ? IDLE : DATA) : START;
      DATA:    state_n = (samp && last_data) ? (PARITY != 0 ? PAR : STOP) : DATA;
      PAR:     state_n = samp ? STOP : PAR;
      STOP:    state_n = (samp && last_stop) ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    push = state == STOP && samp && last_stop;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt   <= '0;
      bidx  <= '0;
      shreg <= '0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
    end else begin
      cnt  <= (state == IDLE || cnt == CW'(TICK_CNT - 1)) ? '0 : cnt + 1'b1;
      bidx <= (state != state_n) ? '0 : samp ? bidx + 1'b1 : bidx;
      if (state == IDLE) {perr, ferr} <= 2'b00;
      if (samp && state == DATA) shreg <= {bit_v, shreg[DATA_BITS-1:1]};
      if (samp && state == PAR)  perr  <= ((^shreg) ^ bit_v) != (PARITY == 1);
      if (samp && state == STOP) ferr  <= ferr | ~bit_v;
    end
  // A full FIFO still accepts a frame when the head is popped in the same cycle.
  assign pop  = bus.valid & bus.ready;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign wr   = push && (!full || pop);
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= {ferr | ~bit_v, perr, shreg};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp          <= '0;
      rp          <= '0;
      bus.overrun <= 1'b0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      bus.overrun <= push && full && !pop;
    end
  assign bus.valid = wp != rp;
  assign {bus.frame_err, bus.parity_err, bus.data_out} = bus.valid ? mem[rp[AW-1:0]] : '0;
endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receive front end for the input module: deserialises an asynchronous serial line into words of configurable width with optional parity and one or two stop bits. Received words, with per-word parity and framing error flags, are buffered in a small first-word-fall-through FIFO and handed to downstream logic over a valid/ready handshake. It replaces the fixed 8N1, unbuffered receiver wherever back-pressure or error reporting is required.

## Interface
- CLK_FREQ, 100000000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate; TICK_CNT = CLK_FREQ/BAUD_RATE (integer division), HALF = TICK_CNT/2.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: receive buffer depth; power of two, ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial line; idle high; asynchronous to clk.
- data_out  output  DATA_BITS  head-of-FIFO data, LSB = first received bit.
- parity_err  output  1  head word failed parity check (always 0 when PARITY=0).
- frame_err  output  1  head word had at least one low stop bit.
- valid  output  1  FIFO non-empty; data_out and flags are meaningful.
- ready  input  1  consumer accepts head word when valid && ready.
- overrun  output  1  one-cycle pulse: a completed frame was dropped because the FIFO was full.

## Operation
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s plus a delayed copy for edge detection.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: waits for a 1→0 transition on rx_s; a line held low does not start a frame. On the edge: bit counter cnt ← 0, state → START.
- cnt counts 0..TICK_CNT−1 per bit period, wrapping to 0; the bit sample is taken when cnt == HALF.
- START: at the sample, if rx is high → false start, return to IDLE with no output; otherwise → DATA.
- DATA: shifts in DATA_BITS samples LSB-first, then → PAR if PARITY≠0, else → STOP.
- PAR: samples one bit; parity_err for the frame = (XOR of data ^ bit) != (PARITY==1).
- STOP: samples STOP_BITS bits; any low sample sets frame_err. After the last stop sample the frame {frame_err, parity_err, data} is pushed and state → IDLE.
- A frame with frame_err is still pushed. If the line remains low, the next start requires rx_s to return high and then fall again.
- FIFO: push on frame completion, pop on valid && ready. Simultaneous push and pop are both performed, and occupancy is unchanged. A push while full, with no pop in the same cycle, drops the new frame and pulses overrun; stored contents are untouched.
- Reset (at any time, including mid-frame): state IDLE, cnt 0, FIFO empty; valid, overrun, data_out, parity_err, frame_err all 0. The partial frame is discarded.

## Timing
- Synchroniser latency is 2 clk from the rx pin to rx_s.
- Push occurs on the clk edge that registers the final stop-bit sample. valid is high in the following cycle, i.e. 1 clk after the sample when the FIFO was empty.
- Output is first-word-fall-through: data_out and flags change only on a pop or on a push into an empty FIFO, never while valid && !ready.
- overrun is high for exactly the one cycle of the dropped push.
- The sample point relative to the true bit centre is offset by the synchroniser and edge-detect delay (3 clk). This offset is acceptable for TICK_CNT ≥ 16.

## Configuration
- UART_RX_MAJORITY_EN defined: each bit value (start, data, parity, stop) is the 2-of-3 majority of rx_s at cnt == HALF−1, HALF and HALF+1, and the decision is made at HALF+1. Requires TICK_CNT ≥ 8.
- Undefined: a single rx_s sample at cnt == HALF; no extra registers.

## Test plan
- Default config with CLK_FREQ=1600000, BAUD_RATE=100000 (TICK_CNT=16), ready=1, send 8N1 0xA5 → one cycle valid=1, data_out=0xA5, parity_err=0, frame_err=0, overrun=0.
- PARITY=2, send 0x03 with parity bit 1 (wrong) → data_out=0x03, parity_err=1. Resend with parity bit 0 → parity_err=0.
- Send 0x55 with stop bit driven low and rx held low for 40 clk → data_out=0x55, frame_err=1, no second frame. rx high then a valid 0x12 frame → 0x12 received.
- rx low pulse of 4 clk → false start; valid stays 0. With UART_RX_MAJORITY_EN, a 1-clk glitch at the centre of data bit 3 of 0xF0 → 0xF0 received unchanged.
- FIFO_DEPTH=4, ready=0, send 0x01..0x05 → overrun pulses once on the fifth frame. Then ready=1 drains 0x01, 0x02, 0x03, 0x04 on consecutive cycles, and valid drops after the fourth.
- Assert reset after 3 data bits of a frame → all outputs 0, FIFO empty. After release, a clean 0x3C frame → data_out=0x3C, no flags.
